// File: rtl/aha_sram_ahb_bridge.sv
// AHB-Lite slave bridging onto a single-port synchronous SRAM macro.
// Option: define AHA_SRAM_BRIDGE_RDATA_REG_EN for registered HRDATA.
module aha_sram_ahb_bridge #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH+1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  SRAM_CEn,
  output logic [3:0]            SRAM_WEn,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [31:0]           SRAM_D,
  input  logic [31:0]           SRAM_Q
);

`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
  typedef enum logic [1:0] {IDLE, ERR1, ERR2, RD_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
`endif

  state_t state_q, state_d;
  logic hreadyout_q, hreadyout_d;
  logic hresp_q, hresp_d;
  logic dp_rd_q, dp_rd_d;
  logic dp_wr_q, dp_wr_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
  logic [3:0] dp_mask_q, dp_mask_d;
  logic buf_full_q, buf_full_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [3:0] buf_mask_q, buf_mask_d;
  logic [31:0] buf_data_q, buf_data_d;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
  logic [31:0] rdata_q, rdata_d;
`endif

  logic live, acc, bad, rd_ap, wr_ap;
  logic wr_now, commit, fwd;
  logic [3:0] mask;
  logic [31:0] merged;
  logic [ADDR_WIDTH-1:0] ap_addr;
  logic unused_ok;

  assign unused_ok = HTRANS[0];
  assign live = ~RESET;
  assign ap_addr = HADDR[ADDR_WIDTH+1:2];
  assign acc = live & HSEL & HTRANS[1] & HREADY;
  assign rd_ap = acc & ~bad & ~HWRITE;
  assign wr_ap = acc & ~bad & HWRITE;
  assign wr_now = live & dp_wr_q & HREADY;
  assign commit = live & buf_full_q & ~rd_ap & ~wr_now;
  assign fwd = dp_rd_q & buf_full_q &
               (dp_addr_q == buf_addr_q);

  // byte lanes and legality of the address phase
  always_comb begin
    mask = 4'b0000;
    bad = 1'b1;
    unique case (1'b1)
      HSIZE == 3'd0: begin
        mask = 4'b0001 << HADDR[1:0];
        bad = 1'b0;
      end
      HSIZE == 3'd1: begin
        mask = HADDR[1] ? 4'b1100 : 4'b0011;
        bad = HADDR[0];
      end
      HSIZE == 3'd2: begin
        mask = 4'b1111;
        bad = |HADDR[1:0];
      end
      default: ;
    endcase
  end

  // overlay buffered bytes on SRAM data for read-after-write
  always_comb begin
    merged = SRAM_Q;
    for (int i = 0; i < 4; i++) begin
      if (fwd & buf_mask_q[i])
        merged[8*i +: 8] = buf_data_q[8*i +: 8];
    end
  end

  // next state: data phase, write buffer, response FSM
  always_comb begin
    state_d = state_q;
    dp_rd_d = dp_rd_q;
    dp_wr_d = dp_wr_q;
    dp_addr_d = dp_addr_q;
    dp_mask_d = dp_mask_q;
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    if (HREADY) begin
      dp_rd_d = rd_ap;
      dp_wr_d = wr_ap;
      dp_addr_d = ap_addr;
      dp_mask_d = mask;
    end
    if (wr_now & rd_ap) begin
      buf_full_d = 1'b1;
      buf_addr_d = dp_addr_q;
      buf_mask_d = dp_mask_q;
      buf_data_d = HWDATA;
    end else if (commit) begin
      buf_full_d = 1'b0;
    end
    unique case (state_q)
      ERR1: state_d = ERR2;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
      RD_WAIT: state_d = IDLE;
`endif
      default: begin
        if (acc & bad)
          state_d = ERR1;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
        else if (rd_ap)
          state_d = RD_WAIT;
`endif
        else
          state_d = IDLE;
      end
    endcase
    hreadyout_d = (state_d != ERR1);
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
    hreadyout_d = hreadyout_d & (state_d != RD_WAIT);
    rdata_d = (state_q == RD_WAIT) ? merged : rdata_q;
`endif
    hresp_d = (state_d == ERR1) | (state_d == ERR2);
  end

  // SRAM port: read addr phase, then write data phase, then commit
  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = 4'hF;
    SRAM_A = '0;
    SRAM_D = '0;
    if (rd_ap) begin
      SRAM_CEn = 1'b0;
      SRAM_A = ap_addr;
    end else if (wr_now) begin
      SRAM_CEn = 1'b0;
      SRAM_A = dp_addr_q;
      SRAM_D = HWDATA;
      SRAM_WEn = ~dp_mask_q;
    end else if (commit) begin
      SRAM_CEn = 1'b0;
      SRAM_A = buf_addr_q;
      SRAM_D = buf_data_q;
      SRAM_WEn = ~buf_mask_q;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP = hresp_q;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
  assign HRDATA = rdata_q;
`else
  assign HRDATA = (live & dp_rd_q) ? merged : '0;
`endif

  // registers with synchronous reset; reset drops any buffered write
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q <= 1'b0;
      dp_rd_q <= 1'b0;
      dp_wr_q <= 1'b0;
      dp_addr_q <= '0;
      dp_mask_q <= '0;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
      dp_rd_q <= dp_rd_d;
      dp_wr_q <= dp_wr_d;
      dp_addr_q <= dp_addr_d;
      dp_mask_q <= dp_mask_d;
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_mask_q <= buf_mask_d;
      buf_data_q <= buf_data_d;
`ifdef AHA_SRAM_BRIDGE_RDATA_REG_EN
      rdata_q <= rdata_d;
`endif
    end
  end

endmodule
